multi_digit_counter_7seg: RTL and testbench
===========================================

Name: multi_digit_counter_7seg

Overview:
- Parametrised N-digit up/down counter driven by two push buttons (KEY-style, active-low, bouncing).
- Each button is synchronised and debounced; a press produces exactly one count step.
- Runs in hex or BCD mode, selected at run time.
- Drives N_DIGITS active-low seven-segment displays directly, one static digit per display, with no multiplexing.

Parameters:
- N_DIGITS, 4, number of 4-bit digits and displays (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a level change (>=1).
- DB_W, 16, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- inc_button  in  1  raw button, active-low (pressed = 0); each press counts up.
- dec_button  in  1  raw button, active-low; each press counts down.
- decimal_mode  in  1  1 = BCD digits 0-9, 0 = hex digits 0-F.
- count  out  4*N_DIGITS  current value; digit i is count[4i+3:4i], digit 0 is least significant.
- seven_segment  out  7*N_DIGITS  active-low segments; digit i is [7i+6:7i], bit order g..a (bit0 = a).
- wrap  out  1  one-cycle pulse when the count wraps in either direction.

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - count = 0 and wrap = 0.
  - Synchroniser and debounced-state registers = 1 (released).
  - Debounce counters = 0 and registered mode = decimal_mode default 0.
  - seven_segment shows "0" on every digit: 7'b1000000 per digit.
- A press aborted by reset is lost; after release of reset no spurious event is generated.
- Per-button pipeline:
  - 2-FF synchroniser, then a debounce filter.
  - The filter counter increments on each cycle where the synchronised value differs from the stable state, and clears on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the stable state takes the new value and the counter clears.
  - A press event is stable going 1->0. Release (0->1) produces no event.
- Latency: pin held low from edge k gives a count update at edge k+DEBOUNCE_CYCLES+2. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Step rules:
  - inc event only: count+1. dec event only: count-1.
  - inc and dec events on the same cycle cancel: no change, no wrap.
- Hex mode: plain binary arithmetic mod 16^N_DIGITS.
- BCD mode: per-digit carry/borrow at 9/0.
  - Up from all-9s gives all-0s. Down from all-0s gives all-9s.
- wrap is asserted for exactly the cycle after a step that crosses the max/0 boundary.
- decimal_mode is registered. When the registered value changes, count is cleared to 0 on the following edge; button events in that cycle are ignored and wrap stays 0.
- seven_segment is combinational from count, active-low. Patterns (segments g..a):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Holding a button produces exactly one event; there is no auto-repeat.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: every zero digit more significant than the highest non-zero digit is blanked (7'b1111111). Digit 0 is never blanked, so a value of 0 shows a single "0". count is unaffected.
- Not defined: all digits are always displayed, including leading zeros.

Test Plan:
All tests use N_DIGITS=4 and DEBOUNCE_CYCLES=4.
- Reset, hex mode, then 3 clean inc presses (each held 10 cycles) -> count=16'h0003; digit 0 segments 7'b0110000; digits 1-3 show 7'b1000000. Each step lands exactly 6 edges after the pin falls.
- Bounce: inc low for 3 cycles, high for 2, then low for 10 -> exactly one increment, timed from the final falling edge. A 3-cycle-only pulse -> no change.
- Hex wrap: preload 16'hFFFF via 1 dec press from 0 (wrap pulses), then 1 inc press -> count=16'h0000 and one wrap pulse.
- BCD mode: set decimal_mode=1 (count clears), 10 inc presses -> count=16'h0010. Then 11 dec presses -> count=16'h9999 and wrap=1 for one cycle.
- Both buttons pressed in the same cycle -> count unchanged, wrap=0. Reset asserted mid-debounce (counter at 2) -> count=0, and no event after release of reset with the button still held.
- With LEADING_ZERO_BLANK_EN and count=16'h0042 -> digits 3 and 2 are 7'b1111111. With count=0 -> only digit 0 is lit.

Source files
------------

// File: rtl/multi_digit_counter_7seg.sv
// N-digit up/down counter (hex or BCD) stepped by two debounced active-low buttons,
// driving one static active-low seven-segment display per digit. Optional macro: LEADING_ZERO_BLANK_EN.
module multi_digit_counter_7seg #(
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_button,
  input  logic                    dec_button,
  input  logic                    decimal_mode,
  output logic [4*N_DIGITS-1:0]   count,
  output logic [7*N_DIGITS-1:0]   seven_segment,
  output logic                    wrap
);

  localparam int CW = 4*N_DIGITS;

  logic [1:0]      raw;
  logic [1:0]      sync1, sync2, stable, armed, evt;
  logic [DB_W-1:0] db_cnt [2];
  logic            primed;
  logic            mode_q, mode_prev, mode_change;
  logic [CW-1:0]   next_count;
  logic            next_wrap;
  logic [CW:0]     stepped;

  function automatic logic [CW:0] hex_step(input logic [CW-1:0] v, input logic up);
    logic [CW:0] t;
    t = up ? ({1'b0, v} + (CW+1)'(1)) : ({1'b0, v} - (CW+1)'(1));
    return t;
  endfunction

  // MSB of the result is the carry/borrow out of the top digit, i.e. the wrap flag
  function automatic logic [CW:0] bcd_step(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d >= 4'd9) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = d + 4'd1; carry = 1'b0; end
        end else begin
          if (d == 4'd0) r[4*i +: 4] = 4'd9;
          else begin r[4*i +: 4] = d - 4'd1; carry = 1'b0; end
        end
      end
    end
    return {carry, r};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign raw = {dec_button, inc_button};

  // Synchroniser + debounce; a button only arms once it has been seen released
  // after reset, so a button held through reset never yields a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      stable    <= 2'b11;
      armed     <= 2'b00;
      evt       <= 2'b00;
      primed    <= 1'b0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      primed <= 1'b1;
      armed  <= armed | ({2{primed}} & sync1);
      for (int b = 0; b < 2; b++) begin
        evt[b] <= 1'b0;
        if (sync2[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES-1)) begin
          db_cnt[b] <= '0;
          stable[b] <= sync2[b];
          evt[b]    <= ~sync2[b] & armed[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= 1'b0;
      mode_prev <= 1'b0;
    end else begin
      mode_q    <= decimal_mode;
      mode_prev <= mode_q;
    end
  end

  assign mode_change = mode_q != mode_prev;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    stepped    = '0;
    if (mode_change) begin
      next_count = '0;
    end else if (evt[0] ^ evt[1]) begin
      stepped    = mode_q ? bcd_step(count, evt[0]) : hex_step(count, evt[0]);
      next_count = stepped[CW-1:0];
      next_wrap  = stepped[CW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
`endif

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      seven_segment[7*i +: 7] = seg7(count[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = N_DIGITS-1; i > 0; i--) begin
      if (lead && count[4*i +: 4] == 4'd0) seven_segment[7*i +: 7] = 7'b1111111;
      else lead = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_multi_digit_counter_7seg.sv
// Directed bench for multi_digit_counter_7seg (N_DIGITS=4, DEBOUNCE_CYCLES=4).
module tb_multi_digit_counter_7seg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inc_button = 1'b1;
  logic        dec_button = 1'b1;
  logic        decimal_mode = 1'b0;
  logic [15:0] count;
  logic [27:0] seven_segment;
  logic        wrap;
  int          tests = 0;
  int          fails = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  multi_digit_counter_7seg #(.N_DIGITS(4), .DEBOUNCE_CYCLES(4), .DB_W(16)) dut (
    .clk(clk), .reset(reset), .inc_button(inc_button), .dec_button(dec_button),
    .decimal_mode(decimal_mode), .count(count), .seven_segment(seven_segment), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons low for 7 edges: the step lands on the last one.
  task automatic press(input logic i, input logic d);
    inc_button = ~i;
    dec_button = ~d;
    repeat (7) tick();
  endtask

  task automatic release_btns();
    inc_button = 1'b1;
    dec_button = 1'b1;
    repeat (8) tick();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL reset_count got %h want 0000", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b want 0", wrap); end
    tests++; if (seven_segment !== {LZ, LZ, LZ, S0}) begin
      fails++; $display("FAIL reset_seg got %b want %b", seven_segment, {LZ, LZ, LZ, S0});
    end
    tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_inc_timing();
    for (int n = 1; n <= 3; n++) begin
      inc_button = 1'b0;
      repeat (6) tick();
      tests++; if (count !== 16'(n-1)) begin fails++; $display("FAIL inc_early%0d got %h want %h", n, count, 16'(n-1)); end
      tick();
      tests++; if (count !== 16'(n)) begin fails++; $display("FAIL inc_land%0d got %h want %h", n, count, 16'(n)); end
      repeat (3) tick();
      release_btns();
    end
    tests++; if (count !== 16'h0003) begin fails++; $display("FAIL inc_total got %h want 0003", count); end
    tests++; if (seven_segment[6:0] !== S3) begin fails++; $display("FAIL inc_seg0 got %b want %b", seven_segment[6:0], S3); end
    tests++; if (seven_segment[27:7] !== {S0, S0, S0} && seven_segment[27:7] !== {LZ, LZ, LZ}) begin
      fails++; $display("FAIL inc_seg_hi got %b want %b", seven_segment[27:7], {LZ, LZ, LZ});
    end
  endtask

  task automatic test_bounce();
    inc_button = 1'b0; repeat (3) tick();
    inc_button = 1'b1; repeat (2) tick();
    inc_button = 1'b0;
    repeat (6) tick();
    tests++; if (count !== 16'h0003) begin fails++; $display("FAIL bounce_early got %h want 0003", count); end
    tick();
    tests++; if (count !== 16'h0004) begin fails++; $display("FAIL bounce_land got %h want 0004", count); end
    repeat (3) tick();
    release_btns();
    inc_button = 1'b0; repeat (3) tick();
    inc_button = 1'b1; repeat (15) tick();
    tests++; if (count !== 16'h0004) begin fails++; $display("FAIL glitch got %h want 0004", count); end
  endtask

  task automatic test_hex_wrap();
    pulse_reset();
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL wrap_start got %h want 0000", count); end
    press(1'b0, 1'b1);
    tests++; if (count !== 16'hFFFF) begin fails++; $display("FAIL dec_wrap_count got %h want FFFF", count); end
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL dec_wrap_pulse got %b want 1", wrap); end
    tick();
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL dec_wrap_end got %b want 0", wrap); end
    release_btns();
    press(1'b1, 1'b0);
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL inc_wrap_count got %h want 0000", count); end
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL inc_wrap_pulse got %b want 1", wrap); end
    tick();
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL inc_wrap_end got %b want 0", wrap); end
    release_btns();
  endtask

  task automatic test_bcd();
    press(1'b1, 1'b0); release_btns();
    decimal_mode = 1'b1;
    repeat (3) tick();
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL mode_clear got %h want 0000", count); end
    for (int n = 0; n < 10; n++) begin press(1'b1, 1'b0); release_btns(); end
    tests++; if (count !== 16'h0010) begin fails++; $display("FAIL bcd_up got %h want 0010", count); end
    for (int n = 0; n < 10; n++) begin press(1'b0, 1'b1); release_btns(); end
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL bcd_down got %h want 0000", count); end
    press(1'b0, 1'b1);
    tests++; if (count !== 16'h9999) begin fails++; $display("FAIL bcd_wrap_count got %h want 9999", count); end
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL bcd_wrap_pulse got %b want 1", wrap); end
    tick();
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL bcd_wrap_end got %b want 0", wrap); end
    release_btns();
  endtask

  task automatic test_both();
    press(1'b1, 1'b1);
    tests++; if (count !== 16'h9999) begin fails++; $display("FAIL both_count got %h want 9999", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL both_wrap got %b want 0", wrap); end
    release_btns();
  endtask

  task automatic test_reset_mid();
    inc_button = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL midreset_count got %h want 0000", count); end
    tick();
    reset = 1'b1;
    repeat (20) tick();
    tests++; if (count !== 16'h0000) begin fails++; $display("FAIL midreset_held got %h want 0000", count); end
    release_btns();
    press(1'b1, 1'b0);
    tests++; if (count !== 16'h0001) begin fails++; $display("FAIL rearm got %h want 0001", count); end
    release_btns();
  endtask

  task automatic test_digits();
    decimal_mode = 1'b0;
    repeat (3) tick();
    for (int n = 0; n < 66; n++) begin press(1'b1, 1'b0); release_btns(); end
    tests++; if (count !== 16'h0042) begin fails++; $display("FAIL d42_count got %h want 0042", count); end
    tests++; if (seven_segment !== {LZ, LZ, S4, S2}) begin
      fails++; $display("FAIL d42_seg got %b want %b", seven_segment, {LZ, LZ, S4, S2});
    end
  endtask

  initial begin
    test_reset();
    test_inc_timing();
    test_bounce();
    test_hex_wrap();
    test_bcd();
    test_both();
    test_reset_mid();
    test_digits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
